// File: rtl/fwd_arb_pkg.sv
// Shared definitions for the forwarding arbiter: FSM encoding and select-width helper.
package fwd_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_e;

   // Width of a binary index into n items; at least one bit even for tiny n.
   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fwd_arb_ctrl_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after last+1, wrapping.
module rr_pick
   import fwd_arb_pkg::*;
#(
   parameter int N_CORES   = 4,
   parameter int SEL_WIDTH = sel_w(N_CORES)
) (
   input  logic [N_CORES-1:0]   req,
   input  logic [SEL_WIDTH-1:0] last,
   output logic [SEL_WIDTH-1:0] pick,
   output logic                 any
);

   logic [N_CORES-1:0] rot;
   int                 start_idx;
   int                 off_idx;

   // Rotate so the highest-priority core lands at bit 0, encode, then add the rotation back.
   always_comb begin
      start_idx = (int'(last) + 1) % N_CORES;
      rot       = '0;
      for (int i = 0; i < N_CORES; i++) begin
         for (int j = 0; j < N_CORES; j++) begin
            if (j == (start_idx + i) % N_CORES) begin
               rot[i] = req[j];
            end
         end
      end
      off_idx = 0;
      for (int i = N_CORES - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off_idx = i;
         end
      end
      any  = |req;
      pick = SEL_WIDTH'((start_idx + off_idx) % N_CORES);
   end

endmodule

// File: rtl/fwd_arb_ctrl.sv
// Round-robin grant controller driving the forwarding mux-tree select lines.
// Handshake: sel_valid offers the granted core; fwd_ready gates a new pick in IDLE only; fwd_done ends the grant.
module fwd_arb_ctrl
   import fwd_arb_pkg::*;
#(
   parameter int N_CORES   = 4,
   parameter int SEL_WIDTH = sel_w(N_CORES)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_CORES-1:0]   req,
   input  logic                 fwd_ready,
   input  logic                 fwd_done,
   output logic [SEL_WIDTH-1:0] sel,
   output logic                 sel_valid,
   output logic [N_CORES-1:0]   gnt,
   output logic [N_CORES-1:0]   rel,
   output arb_state_e           dbg_state
);

   arb_state_e           state_q, state_d;
   logic [SEL_WIDTH-1:0] sel_q, sel_d;
   logic                 valid_q, valid_d;
   logic [N_CORES-1:0]   gnt_q, gnt_d;
   logic [N_CORES-1:0]   rel_q, rel_d;
   logic [SEL_WIDTH-1:0] last_q, last_d;

   logic [SEL_WIDTH-1:0] pick;
   logic                 pick_any;

   rr_pick #(
      .N_CORES   (N_CORES),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_rr_pick (
      .req  (req),
      .last (last_q),
      .pick (pick),
      .any  (pick_any)
   );

   // Reset leaves last at the top index so core 0 wins the first search.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         valid_q <= 1'b0;
         gnt_q   <= '0;
         rel_q   <= '0;
         last_q  <= SEL_WIDTH'(N_CORES - 1);
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         gnt_q   <= gnt_d;
         rel_q   <= rel_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (fwd_ready && pick_any) state_d = ST_GRANT;
         ST_GRANT:   if (fwd_done) state_d = ST_RELEASE;
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      sel_d   = sel_q;
      valid_d = valid_q;
      gnt_d   = gnt_q;
      rel_d   = '0;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (fwd_ready && pick_any) begin
               sel_d   = pick;
               gnt_d   = N_CORES'(1) << pick;
               valid_d = 1'b1;
            end
         end
         ST_GRANT: begin
            if (fwd_done) begin
               valid_d = 1'b0;
               gnt_d   = '0;
               rel_d   = N_CORES'(1) << sel_q;
               last_d  = sel_q;
            end
         end
         ST_RELEASE: begin
            valid_d = 1'b0;
            gnt_d   = '0;
         end
         default: begin
            valid_d = 1'b0;
            gnt_d   = '0;
         end
      endcase
   end

   assign sel       = sel_q;
   assign sel_valid = valid_q;
   assign gnt       = gnt_q;
   assign rel       = rel_q;
   assign dbg_state = state_q;

endmodule

// File: doc/fwd_arb_ctrl.md
# fwd_arb_ctrl

Round-robin grant controller for the forwarding arbiter. It sits directly upstream of the mux tree and drives the tree's select lines. It watches which packet-filter cores hold an accepted packet awaiting forwarding, grants exactly one of them to the forwarder at a time, holds that grant until the forwarder finishes reading, and then pulses a release back to the granted core.

## Interface
Parameters:
- `N_CORES`, default 4: number of cores arbitrated, ≥2.
- `SEL_WIDTH`, default `$clog2(N_CORES)`: width of the binary select fed to the mux tree.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_CORES  bit i high means core i holds a packet ready for forwarding; level signal.
- `fwd_ready`  in  1  forwarder can accept a new packet.
- `fwd_done`  in  1  one-cycle pulse: forwarder has finished reading the granted packet.
- `sel`  out  SEL_WIDTH  binary index of the granted core; drives the mux tree select.
- `sel_valid`  out  1  `sel` and `gnt` are meaningful; the mux tree output is valid for the forwarder.
- `gnt`  out  N_CORES  one-hot grant, equal to `1 << sel` while `sel_valid` is high, else 0.
- `rel`  out  N_CORES  one-cycle, one-hot release pulse to the core whose packet was forwarded.

## Operation
- State machine with three states: IDLE, GRANT, RELEASE. All outputs are registered.
- Round-robin pointer `last` (SEL_WIDTH bits) holds the most recently released core.
- IDLE:
  - If `fwd_ready` and `|req`: pick the first set `req` bit searching from `last+1` upward, wrapping modulo N_CORES.
  - Register `sel`=pick, `gnt`=one-hot(pick), `sel_valid`=1, then go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - `sel`, `gnt` and `sel_valid` hold steady.
  - On `fwd_done`: clear `sel_valid` and `gnt`, assert `rel[sel]`, set `last`=`sel`, then go to RELEASE.
- RELEASE:
  - `rel` is high for exactly this one cycle.
  - The next edge clears `rel` and returns to IDLE.
  - No new pick is made in RELEASE, so the core sees its release before `req` is re-sampled.
- Boundary rules:
  - `req[sel]` dropping during GRANT is ignored; the grant is held until `fwd_done`.
  - `fwd_done` in IDLE or RELEASE is ignored.
  - `fwd_ready` is sampled only in IDLE; dropping it during GRANT has no effect.
  - Wrap-around: with `last`=N_CORES-1, the search starts at core 0.
  - A single requester is granted repeatedly regardless of `last`.
  - `sel` holds its last value when `sel_valid`=0; consumers must qualify it with `sel_valid`.
- Reset, asynchronous and valid mid-operation:
  - State becomes IDLE.
  - `sel`=0, `sel_valid`=0, `gnt`=0, `rel`=0, and `last`=N_CORES-1 so that core 0 has first priority.
  - An in-flight grant is abandoned with no `rel` pulse.

## Timing
- Request to grant: `req` and `fwd_ready` high in IDLE at edge k gives `sel_valid`=1 after edge k.
- Done to release: `fwd_done` sampled high at edge m gives `rel` high after edge m, and only during the cycle following edge m.
- Minimum grant-to-grant spacing is 3 cycles: GRANT (≥1 cycle), then RELEASE, then IDLE pick.
- Pick logic is combinational over `req` and `last`. Its depth is O(N_CORES); with N_CORES ≤ 16 it closes in a single cycle.

## Structure
- Shared package `fwd_arb_pkg` holds:
  - the state encoding (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2);
  - a `clog2`-style width function reused by the mux tree for SEL_WIDTH.
- One combinational sub-module, `rr_pick`: inputs `req` and `last`; outputs `pick` (SEL_WIDTH) and `any` (1).
  - Implemented as a request vector rotated by `last+1`, a lowest-set-bit priority encoder, and a modular add-back.
  - Verified standalone by exhaustive sweep for N_CORES=4.

## Test plan
All scenarios use N_CORES=4.
- Reset, then `req`=4'b1111 with `fwd_ready`=1 and `fwd_done` pulsed 2 cycles after each grant → grants in order 0,1,2,3,0; each `rel` is a single-cycle one-hot matching the prior `sel`.
- `req`=4'b0100 held, repeated `fwd_done` → `sel`=2 every grant; `gnt`=4'b0100; spacing exactly 3 cycles when `fwd_done` is given on the first GRANT cycle.
- Wrap: force `last`=3 by granting core 3 alone, then `req`=4'b1001 → next grant is core 0, then core 3.
- `fwd_ready`=0 with `req`=4'b0010 for 10 cycles → `sel_valid` stays 0. Raise `fwd_ready` → `sel_valid`=1, `sel`=1 one edge later. Drop `req[1]` mid-GRANT → grant held until `fwd_done`.
- Spurious `fwd_done` in IDLE → no `rel`, state unchanged. `fwd_done` in RELEASE → ignored, with no double `rel`.
- Assert `rst_n`=0 asynchronously mid-GRANT (between edges) → `sel_valid`, `gnt` and `rel` go to 0 immediately. After release of reset with `req`=4'b1010, first grant is core 1.
